// File: rtl/usb_stream_bridge_pkg.sv
// usb_stream_bridge shared definitions: register map,
// STATUS/CONTROL bit positions and the STATUS word builder.
package usb_stream_bridge_pkg;

    localparam logic [1:0] REG_STATUS  = 2'd0;
    localparam logic [1:0] REG_RX_DATA = 2'd1;
    localparam logic [1:0] REG_TX_DATA = 2'd2;
    localparam logic [1:0] REG_CONTROL = 2'd3;

    localparam int ST_RX_COUNT_LSB = 0;
    localparam int ST_TX_FREE_LSB  = 6;
    localparam int ST_TX_OVF       = 12;
    localparam int ST_RX_IRQ_EN    = 13;

    localparam int CTL_CLR_OVF  = 0;
    localparam int CTL_FLUSH_RX = 1;
    localparam int CTL_FLUSH_TX = 2;
    localparam int CTL_IRQ_EN   = 3;

    localparam int RX_VALID_BIT = 15;

    function automatic logic [15:0] status_word(
        input logic [5:0] rx_count,
        input logic [5:0] tx_free,
        input logic       tx_ovf,
        input logic       irq_en
    );
        logic [15:0] w;
        w = '0;
        w[ST_RX_COUNT_LSB +: 6] = rx_count;
        w[ST_TX_FREE_LSB +: 6]  = tx_free;
        w[ST_TX_OVF]            = tx_ovf;
        w[ST_RX_IRQ_EN]         = irq_en;
        return w;
    endfunction

endpackage

// File: rtl/usb_stream_bridge_stream_fifo.sv
// stream_fifo: synchronous FIFO with flush, occupancy count and a
// registered head output.
// Ports: clk/rst, push+din, pop, flush -> head, count, full, empty.
module stream_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_next;
    logic [AW:0]      cnt_d;
    logic [WIDTH-1:0] head_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full & ~flush;
    assign pop_ok  = pop & ~empty & ~flush;
    assign rd_next = rd_ptr + AW'(pop_ok);

    always_comb begin
        cnt_d = count;
        if (flush) begin
            cnt_d = '0;
        end else begin
            unique case ({push_ok, pop_ok})
                2'b10:   cnt_d = count + 1'b1;
                2'b01:   cnt_d = count - 1'b1;
                default: cnt_d = count;
            endcase
        end
    end

    // The head register tracks the entry at rd_next after this edge.
    // A push lands on that slot only when the FIFO is draining to
    // empty (or is empty), so it bypasses memory. Empty reads as zero
    // so no stale byte is ever presented.
    always_comb begin
        head_d = '0;
        if (!flush && cnt_d != '0) begin
            if (push_ok && wr_ptr == rd_next) begin
                head_d = din;
            end else begin
                head_d = mem[rd_next];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            count <= cnt_d;
            head  <= head_d;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                rd_ptr <= rd_next;
            end
        end
    end

endmodule

// File: rtl/usb_stream_bridge.sv
// usb_stream_bridge: USB byte streams <-> four 16-bit bus registers.
// Ports: clk/rst; bus_addr/re/we/wdata/rdata; rx_* stream sink;
// tx_* stream source; irq (RX data available and enabled).
module usb_stream_bridge
    import usb_stream_bridge_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  bus_addr,
    input  logic        bus_re,
    input  logic        bus_we,
    input  logic [15:0] bus_wdata,
    output logic [15:0] bus_rdata,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        irq
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] rx_count;
    logic [CW-1:0] tx_count;
    logic [7:0]    rx_head;
    logic          rx_full;
    logic          rx_empty;
    logic          tx_full;
    logic          tx_empty;

    logic          started;
    logic          tx_ovf;
    logic          irq_en;

    logic          rd_status;
    logic          rd_rx;
    logic          rd_tx;
    logic          rd_ctl;
    logic          wr_tx;
    logic          wr_ctl;
    logic          flush_rx;
    logic          flush_tx;
    logic          clr_ovf;
    logic          ovf_set;
    logic          rx_push;
    logic          rx_pop;
    logic          tx_push;
    logic          tx_pop;

    logic [5:0]    tx_free;
    logic [15:0]   status_w;
    logic [15:0]   rx_word;
    logic [15:0]   ctl_word;
    logic [15:0]   rdata_d;
    logic          unused_wdata;

    assign unused_wdata = ^bus_wdata[15:8];

    assign rd_status = bus_re && bus_addr == REG_STATUS;
    assign rd_rx     = bus_re && bus_addr == REG_RX_DATA;
    assign rd_tx     = bus_re && bus_addr == REG_TX_DATA;
    assign rd_ctl    = bus_re && bus_addr == REG_CONTROL;
    assign wr_tx     = bus_we && bus_addr == REG_TX_DATA;
    assign wr_ctl    = bus_we && bus_addr == REG_CONTROL;

    assign flush_rx = wr_ctl & bus_wdata[CTL_FLUSH_RX];
    assign flush_tx = wr_ctl & bus_wdata[CTL_FLUSH_TX];
    assign clr_ovf  = wr_ctl & bus_wdata[CTL_CLR_OVF];

    // started keeps rx_ready low through reset and for the
    // first edge after release.
    assign rx_ready = started & ~rx_full;
    assign tx_valid = ~tx_empty;
    assign rx_push  = rx_valid & rx_ready;
    assign rx_pop   = rd_rx & ~rx_empty;
    assign tx_push  = wr_tx & ~tx_full;
    assign tx_pop   = tx_valid & tx_ready;
    // Full is judged on start-of-cycle state, so a same-cycle
    // pop does not rescue the byte.
    assign ovf_set  = wr_tx & tx_full & ~flush_tx;

    stream_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .din   (rx_data),
        .pop   (rx_pop),
        .flush (flush_rx),
        .head  (rx_head),
        .count (rx_count),
        .full  (rx_full),
        .empty (rx_empty)
    );

    stream_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .din   (bus_wdata[7:0]),
        .pop   (tx_pop),
        .flush (flush_tx),
        .head  (tx_data),
        .count (tx_count),
        .full  (tx_full),
        .empty (tx_empty)
    );

    assign tx_free  = 6'(DEPTH) - 6'(tx_count);
    assign status_w = status_word(6'(rx_count), tx_free,
                                  tx_ovf, irq_en);

    always_comb begin
        rx_word = '0;
        if (!rx_empty) begin
            rx_word[RX_VALID_BIT] = 1'b1;
            rx_word[7:0]          = rx_head;
        end
        ctl_word             = '0;
        ctl_word[CTL_IRQ_EN] = irq_en;
    end

    always_comb begin
        rdata_d = bus_rdata;
        unique case (1'b1)
            rd_status: rdata_d = status_w;
            rd_rx:     rdata_d = rx_word;
            rd_tx:     rdata_d = '0;
            rd_ctl:    rdata_d = ctl_word;
            default:   rdata_d = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            started   <= 1'b0;
            bus_rdata <= '0;
            tx_ovf    <= 1'b0;
            irq_en    <= 1'b0;
            irq       <= 1'b0;
        end else begin
            started   <= 1'b1;
            bus_rdata <= rdata_d;
            if (ovf_set) begin
                tx_ovf <= 1'b1;
            end else if (clr_ovf) begin
                tx_ovf <= 1'b0;
            end
            if (wr_ctl) begin
                irq_en <= bus_wdata[CTL_IRQ_EN];
            end
            irq <= irq_en & ~rx_empty;
        end
    end

endmodule
